mem_data_if: RTL and testbench

- Data-memory access stage directly downstream of the PC/address select stage.
- Takes the 32-bit byte address it produces, plus store data and access type, and runs one load or store over a word-wide req/ack memory port.
- Handles byte-lane enables, store-data replication, load extraction with sign/zero extension, misalignment detection and an ack timeout.
- Reports completion to the control unit with a one-cycle done pulse.

---
 rtl/mem_data_if_pkg.sv | 63 ++++++
 rtl/mem_data_if_load_extend.sv | 36 +++
 rtl/mem_data_if.sv | 152 +++++++++++++++
 tb/tb_mem_data_if.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_data_if_pkg.sv
// Shared definitions for the data-memory access stage.
package mem_data_if_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned XLEN       = WORD_BYTES * 8;

    // RV32I load/store width codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // FSM encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Memory-port payload held stable for the whole request
    typedef struct packed {
        logic                  we;
        logic [XLEN-1:0]       addr;
        logic [WORD_BYTES-1:0] be;
        logic [XLEN-1:0]       wdata;
    } mem_cmd_t;

    // Width code is a real access for this direction
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !is_store;
            default:          return 1'b0;
        endcase
    endfunction

    // Natural alignment check for halves and words
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_H, F3_HU: return lo[0];
            F3_W:        return lo != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    // Byte-lane enables for the addressed lanes
    function automatic logic [WORD_BYTES-1:0] f3_byte_en(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_B, F3_BU: return 4'b0001 << lo;
            F3_H, F3_HU: return lo[1] ? 4'b1100 : 4'b0011;
            default:     return 4'b1111;
        endcase
    endfunction

    // Replicate narrow store data onto every lane
    function automatic logic [XLEN-1:0] f3_store_data(input logic [2:0] f3, input logic [XLEN-1:0] wd);
        case (f3)
            F3_B:    return {4{wd[7:0]}};
            F3_H:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/mem_data_if_load_extend.sv
// Selects the addressed byte/half of a read word and sign/zero extends it.
module load_extend
    import mem_data_if_pkg::*;
(
    input  logic [XLEN-1:0] i_mem_rdata,
    input  logic [1:0]      i_addr_lo,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_data_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection and extension
    always_comb begin
        w_byte   = 8'h00;
        w_half   = 16'h0000;
        o_data_c = '0;
        case (i_addr_lo)
            2'd0:    w_byte = i_mem_rdata[7:0];
            2'd1:    w_byte = i_mem_rdata[15:8];
            2'd2:    w_byte = i_mem_rdata[23:16];
            default: w_byte = i_mem_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (i_funct3)
            F3_B:    o_data_c = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data_c = {24'h000000, w_byte};
            F3_H:    o_data_c = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data_c = {16'h0000, w_half};
            F3_W:    o_data_c = i_mem_rdata;
            default: o_data_c = '0;
        endcase
    end

endmodule

// File: rtl/mem_data_if.sv
// Data-memory access stage: one load or store over a req/ack word port.
module mem_data_if
    import mem_data_if_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [XLEN-1:0]       addr,
    input  logic                  we,
    input  logic [2:0]            funct3,
    input  logic [XLEN-1:0]       wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [XLEN-1:0]       rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [XLEN-1:0]       mem_addr,
    output logic [WORD_BYTES-1:0] mem_be,
    output logic [XLEN-1:0]       mem_wdata,
    input  logic                  mem_ack,
    input  logic [XLEN-1:0]       mem_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    mem_cmd_t         r_cmd;
    logic [1:0]       r_addr_lo;
    logic [2:0]       r_funct3;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_mem_req;
    logic [XLEN-1:0]  r_rdata;
    logic [XLEN-1:0]  w_load_data;
    logic             w_accept;
    logic             w_bad;
    logic             w_done_nxt;
    logic             w_err_nxt;
    logic             w_load_cap;

    load_extend u_load_extend (
        .i_mem_rdata (mem_rdata),
        .i_addr_lo   (r_addr_lo),
        .i_funct3    (r_funct3),
        .o_data_c    (w_load_data)
    );

    // State and timeout counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, timeout and completion decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
        w_accept    = 1'b0;
        w_bad       = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_load_cap  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_bad    = !f3_legal(funct3, we) || f3_misaligned(funct3, addr[1:0]);
                    if (w_bad) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = S_REQ;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                    w_load_cap  = !r_cmd.we;
                end else if (TIMEOUT != 0) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == CNT_W'(TIMEOUT)) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs, latched request fields and load result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_mem_req <= 1'b0;
            r_rdata   <= '0;
            r_cmd     <= '0;
            r_addr_lo <= 2'b00;
            r_funct3  <= 3'b000;
        end else begin
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_mem_req <= (w_state_nxt == S_REQ);
            if (w_accept) begin
                r_cmd.we    <= we;
                r_cmd.addr  <= {addr[XLEN-1:2], 2'b00};
                r_cmd.be    <= f3_byte_en(funct3, addr[1:0]);
                r_cmd.wdata <= f3_store_data(funct3, wdata);
                r_addr_lo   <= addr[1:0];
                r_funct3    <= funct3;
            end
            if (w_load_cap) begin
                r_rdata <= w_load_data;
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_cmd.we;
    assign mem_addr  = r_cmd.addr;
    assign mem_be    = r_cmd.be;
    assign mem_wdata = r_cmd.wdata;

endmodule

// File: tb/tb_mem_data_if.sv
// Self-checking bench for mem_data_if: per-cycle timeline model plus literal pins.
module tb_mem_data_if;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] wdata = '0;
    logic        busy, done, err, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_checks = 0;
    int n_err    = 0;

    // Expected outputs for the current cycle
    bit          chk_en = 1'b0;
    logic        exp_busy, exp_done, exp_err, exp_req, exp_we;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_be;

    // Observations of the last transaction
    int          seen_done, seen_req;
    logic        seen_err, seen_we;
    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_be;

    mem_data_if #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .we(we),
        .funct3(funct3), .wdata(wdata), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Access size in bytes, 0 for an unknown width code
    function automatic int m_size(input logic [2:0] f);
        case (f)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit m_bad(input logic [31:0] a, input logic w, input logic [2:0] f);
        int sz;
        sz = m_size(f);
        if (sz == 0) return 1'b1;
        if (w && sz < 4 && f[2]) return 1'b1;
        return (int'(a[1:0]) % sz) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] a, input logic [2:0] f);
        logic [3:0] m;
        m = 4'((1 << m_size(f)) - 1);
        return m << a[1:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [2:0] f);
        case (m_size(f))
            1:       return {24'h0, wd[7:0]} * 32'h0101_0101;
            2:       return {16'h0, wd[15:0]} * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] word, input logic [31:0] a, input logic [2:0] f);
        logic [31:0] v, mask;
        int sz;
        sz   = m_size(f);
        v    = word >> (int'(a[1:0]) * 8);
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        v    = v & mask;
        if (!f[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic set_idle();
        exp_busy = 1'b0; exp_req = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    endtask

    // One transaction; ack_at = REQ cycle (1-based) carrying mem_ack, 0 = never
    task automatic txn(input logic [31:0] a, input logic w, input logic [2:0] f, input logic [31:0] wd,
                       input int ack_at, input logic [31:0] word, input bit poke);
        bit bad, ok;
        int nreq;
        bad  = m_bad(a, w, f);
        ok   = (ack_at >= 1) && (ack_at <= int'(TMO));
        nreq = bad ? 0 : (ok ? ack_at : int'(TMO));
        seen_done = -1; seen_req = 0; seen_err = 1'b0; seen_we = 1'b0;
        seen_addr = '0; seen_wdata = '0; seen_be = '0;
        @(posedge clk); #1;
        start = 1'b1; addr = a; we = w; funct3 = f; wdata = wd;
        mem_ack = 1'b0; mem_rdata = $urandom;
        set_idle();
        for (int c = 1; c <= nreq + 2; c++) begin
            @(posedge clk); #1;
            start     = poke && (c == 2);
            addr      = $urandom;
            we        = ~w;
            funct3    = 3'($urandom_range(7, 0));
            wdata     = $urandom;
            mem_ack   = ((c == ack_at) && (c <= nreq)) || (c == nreq + 1);
            mem_rdata = (c == ack_at) ? word : $urandom;
            if (c <= nreq) begin
                exp_busy = 1'b1; exp_req = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
                exp_we = w; exp_addr = {a[31:2], 2'b00};
                exp_be = m_be(a, f); exp_wdata = m_wdata(wd, f);
            end else if (c == nreq + 1) begin
                exp_busy = 1'b1; exp_req = 1'b0; exp_done = 1'b1;
                exp_err  = bad || !ok;
                if (!bad && ok && !w) exp_rdata = m_load(word, a, f);
            end else begin
                set_idle();
            end
            if (mem_req) begin
                seen_req++;
                if (seen_req == 1) begin
                    seen_we = mem_we; seen_addr = mem_addr; seen_be = mem_be; seen_wdata = mem_wdata;
                end
            end
            if (done) begin
                seen_done = c; seen_err = err;
            end
        end
        start = 1'b0; mem_ack = 1'b0;
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("done", 32'(done), 32'(exp_done));
            chk("err", 32'(err), 32'(exp_err));
            chk("mem_req", 32'(mem_req), 32'(exp_req));
            chk("rdata", rdata, exp_rdata);
            if (exp_req) begin
                chk("mem_we", 32'(mem_we), 32'(exp_we));
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_be", 32'(mem_be), 32'(exp_be));
                chk("mem_wdata", mem_wdata, exp_wdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        exp_rdata = '0; exp_we = 1'b0; exp_addr = '0; exp_be = '0; exp_wdata = '0;
        set_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // LW, ack two cycles after mem_req rises
        txn(32'h100, 1'b0, 3'b010, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
        chk("lw_addr", seen_addr, 32'h100);
        chk("lw_be", 32'(seen_be), 32'hF);
        chk("lw_done_cyc", 32'(seen_done), 32'd4);
        chk("lw_err", 32'(seen_err), 32'd0);
        chk("lw_rdata", rdata, 32'hDEAD_BEEF);

        // Byte/half lane extraction
        txn(32'h103, 1'b0, 3'b000, 32'h0, 1, 32'h8011_2233, 1'b0);
        chk("lb_be", 32'(seen_be), 32'h8);
        chk("lb_rdata", rdata, 32'hFFFF_FF80);
        txn(32'h103, 1'b0, 3'b100, 32'h0, 1, 32'h8011_2233, 1'b0);
        chk("lbu_rdata", rdata, 32'h0000_0080);
        txn(32'h102, 1'b0, 3'b001, 32'h0, 1, 32'h8011_2233, 1'b0);
        chk("lh_rdata", rdata, 32'hFFFF_8011);

        // SH zero-wait
        txn(32'h102, 1'b1, 3'b001, 32'h0000_ABCD, 1, 32'h0, 1'b0);
        chk("sh_we", 32'(seen_we), 32'd1);
        chk("sh_be", 32'(seen_be), 32'hC);
        chk("sh_wdata", seen_wdata, 32'hABCD_ABCD);
        chk("sh_done_cyc", 32'(seen_done), 32'd2);
        chk("sh_rdata", rdata, 32'hFFFF_8011);

        // Errors at start
        txn(32'h102, 1'b0, 3'b010, 32'h0, 1, 32'h0, 1'b0);
        chk("lw_mis_done_cyc", 32'(seen_done), 32'd1);
        chk("lw_mis_err", 32'(seen_err), 32'd1);
        chk("lw_mis_req", 32'(seen_req), 32'd0);
        txn(32'h100, 1'b1, 3'b100, 32'h55, 1, 32'h0, 1'b0);
        chk("sb_ill_done_cyc", 32'(seen_done), 32'd1);
        chk("sb_ill_err", 32'(seen_err), 32'd1);
        chk("sb_ill_req", 32'(seen_req), 32'd0);

        // Timeout with a start poke while busy
        txn(32'h200, 1'b0, 3'b010, 32'h0, 0, 32'h0, 1'b1);
        chk("tmo_req_cycles", 32'(seen_req), 32'd4);
        chk("tmo_done_cyc", 32'(seen_done), 32'd5);
        chk("tmo_err", 32'(seen_err), 32'd1);
        chk("tmo_rdata", rdata, 32'hFFFF_8011);

        // Reset in the second REQ cycle
        chk_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; addr = 32'h40; we = 1'b0; funct3 = 3'b010;
        @(posedge clk); #1;
        start = 1'b0;
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_rst_req", 32'(mem_req), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_rdata = '0;
        set_idle();
        chk_en = 1'b1;

        // Normal operation after reset
        txn(32'h300, 1'b1, 3'b010, 32'h1234_5678, 2, 32'h0, 1'b0);
        chk("sw_done_cyc", 32'(seen_done), 32'd3);
        chk("sw_wdata", seen_wdata, 32'h1234_5678);
        txn(32'h101, 1'b1, 3'b000, 32'h0000_00A5, 1, 32'h0, 1'b0);
        chk("sb_be", 32'(seen_be), 32'h2);
        chk("sb_wdata", seen_wdata, 32'hA5A5_A5A5);
        txn(32'h100, 1'b0, 3'b101, 32'h0, 2, 32'h9ABC_F00D, 1'b0);
        chk("lhu_rdata", rdata, 32'h0000_F00D);
        txn(32'h101, 1'b0, 3'b000, 32'h0, 4, 32'h0000_7F00, 1'b0);
        chk("lb_pos_rdata", rdata, 32'h0000_007F);
        chk("ack_at_limit_err", 32'(seen_err), 32'd0);
        txn(32'h104, 1'b0, 3'b011, 32'h0, 1, 32'h0, 1'b0);
        chk("ill_f3_err", 32'(seen_err), 32'd1);
        txn(32'h105, 1'b0, 3'b001, 32'h0, 1, 32'h0, 1'b0);
        chk("lh_mis_err", 32'(seen_err), 32'd1);
        chk("lh_mis_rdata", rdata, 32'h0000_007F);

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
